// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (IF) and load/store (DM) ports
// Optional watchdog: define MEMARB_TIMEOUT_EN to abort accesses left without mem_ack for TIMEOUT cycles.
// Ports: clk, n_rst (sync, active-low)
//   IF side : if_req, if_addr -> if_ack, if_rdata
//   DM side : dm_req, dm_we, dm_addr, dm_wdata -> dm_ack, dm_rdata
//   memory  : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
//   status  : stall_if, stall_mem, err
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("STARVE_MAX and TIMEOUT must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;
  state_t state, state_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic mem_req_nx, mem_we_nx, if_ack_nx, dm_ack_nx, dm_win, done;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_wdata_nx, if_rdata_nx, dm_rdata_nx, rdata_in;
`ifdef MEMARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd, wd_nx;
  logic err_nx;
  assign done = mem_ack | (wd == WLAST);
  assign rdata_in = mem_ack ? mem_rdata : DW'(32'hDEADBEEF);
`else
  assign done = mem_ack;
  assign rdata_in = mem_rdata;
  assign err = 1'b0;
`endif
  // DM has priority unless IF has already been passed over STARVE_MAX times in a row
  assign dm_win = dm_req & (~if_req | (starve_cnt < SMAX));
  assign stall_if = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;
  always_comb begin
    state_nx = state;
    starve_nx = starve_cnt;
    mem_req_nx = mem_req;
    mem_we_nx = mem_we;
    mem_addr_nx = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_ack_nx = 1'b0;
    dm_ack_nx = 1'b0;
    if_rdata_nx = if_rdata;
    dm_rdata_nx = dm_rdata;
`ifdef MEMARB_TIMEOUT_EN
    wd_nx = wd;
    err_nx = err;
`endif
    if (state == IDLE) begin
      // the cycle carrying an ack pulse is a bubble: no arbitration
      if (~if_ack & ~dm_ack & (dm_win | if_req)) begin
        state_nx = dm_win ? GNT_DM : GNT_IF;
        mem_req_nx = 1'b1;
        mem_we_nx = dm_win & dm_we;
        mem_addr_nx = dm_win ? dm_addr : if_addr;
        mem_wdata_nx = dm_win ? dm_wdata : '0;
        starve_nx = ~dm_win ? '0 : (if_req ? starve_cnt + 1'b1 : starve_cnt);
`ifdef MEMARB_TIMEOUT_EN
        wd_nx = '0;
`endif
      end
    end else if (done) begin
      state_nx = IDLE;
      mem_req_nx = 1'b0;
      if_ack_nx = state == GNT_IF;
      dm_ack_nx = state != GNT_IF;
      if_rdata_nx = state == GNT_IF ? rdata_in : if_rdata;
      dm_rdata_nx = state != GNT_IF ? rdata_in : dm_rdata;
`ifdef MEMARB_TIMEOUT_EN
      err_nx = err | ~mem_ack;
`endif
    end else begin
`ifdef MEMARB_TIMEOUT_EN
      wd_nx = wd + 1'b1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nx;
      starve_cnt <= starve_nx;
      mem_req <= mem_req_nx;
      mem_we <= mem_we_nx;
      mem_addr <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_ack <= if_ack_nx;
      dm_ack <= dm_ack_nx;
      if_rdata <= if_rdata_nx;
      dm_rdata <= dm_rdata_nx;
    end
  end
`ifdef MEMARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wd <= '0;
      err <= 1'b0;
    end else begin
      wd <= wd_nx;
      err <= err_nx;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level reference model and per-cycle compare
module tb_mem_port_arbiter;
  localparam int SMAX = 4;
  localparam int TMO = 16;
  localparam logic [31:0] K = 32'h5A5A_0000;
`ifdef MEMARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 0, n_rst = 0, if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic auto_mem = 1, force_ack = 0, auto_ack = 0;
  wire mem_ack = auto_mem ? auto_ack : force_ack;
  logic if_ack, dm_ack, mem_req, mem_we, stall_if, stall_mem, err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );
  int lat = 0, hi_cnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      auto_ack = hi_cnt >= lat;
      hi_cnt++;
    end else begin
      auto_ack = 0;
      hi_cnt = 0;
    end
    mem_rdata = mem_addr ^ K;
  end
  bit m_valid = 0, e_req = 0, e_we = 0, e_ifa = 0, e_dma = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_ifd = 0, e_dmd = 0;
  int own = 0, starve = 0, gcyc = 0;
  int glog[$];
  always @(posedge clk) begin : model
    bit was_ack;
    if (!n_rst) begin
      m_valid = 1; own = 0; starve = 0; gcyc = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_ifa = 0; e_dma = 0; e_ifd = 0; e_dmd = 0; e_err = 0;
    end else if (m_valid) begin
      was_ack = e_ifa | e_dma;
      e_ifa = 0;
      e_dma = 0;
      if (own != 0) begin
        gcyc++;
        if (mem_ack || (TO_EN && gcyc >= TMO)) begin
          if (own == 1) begin
            e_ifa = 1; e_ifd = mem_ack ? mem_rdata : 32'hDEADBEEF;
          end else begin
            e_dma = 1; e_dmd = mem_ack ? mem_rdata : 32'hDEADBEEF;
          end
          if (!mem_ack) e_err = 1;
          own = 0;
          e_req = 0;
        end
      end else if (!was_ack) begin
        if (dm_req && (!if_req || starve < SMAX)) begin
          own = 2; gcyc = 0;
          if (if_req) starve++;
          e_req = 1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
          glog.push_back(2);
        end else if (if_req) begin
          own = 1; gcyc = 0; starve = 0;
          e_req = 1; e_we = 0; e_addr = if_addr; e_wdata = 0;
          glog.push_back(1);
        end
      end
    end
  end
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      chk("c_mem_req", mem_req, e_req);
      chk("c_if_ack", if_ack, e_ifa);
      chk("c_dm_ack", dm_ack, e_dma);
      chk("c_if_rdata", if_rdata, e_ifd);
      chk("c_dm_rdata", dm_rdata, e_dmd);
      chk("c_err", err, e_err);
      chk("c_stall_if", stall_if, if_req & ~e_ifa);
      chk("c_stall_mem", stall_mem, dm_req & ~e_dma);
      if (e_req) begin
        chk("c_mem_we", mem_we, e_we);
        chk("c_mem_addr", mem_addr, e_addr);
        chk("c_mem_wdata", mem_wdata, e_wdata);
      end
    end
  end
  bit if_hold = 0, dm_hold = 0;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (if_ack && !if_hold) if_req = 0;
      if (dm_ack && !dm_hold) dm_req = 0;
    end
  endtask
  task automatic wait_ack(input bit dm, input int maxc, input string nm);
    int c = 0;
    while (!(dm ? dm_ack : if_ack) && c < maxc) begin
      step();
      c++;
    end
    chk(nm, dm ? dm_ack : if_ack, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ndm, hi, code, nxt_we;
    bit got_if, prev, got;
    n_rst = 0;
    step(3);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    n_rst = 1;
    step(2);
    lat = 0; if_addr = 32'h100; if_req = 1;
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_no_ack_yet", if_ack, 0);
    step();
    chk("t1_if_ack", if_ack, 1);
    chk("t1_if_rdata", if_rdata, 32'h5A5A0100);
    chk("t1_model_pin", e_ifd, 32'h5A5A0100);
    step();
    chk("t1_ack_one_cycle", if_ack, 0);
    lat = 1; dm_addr = 32'h200; dm_we = 1; dm_wdata = 32'hA5A5A5A5;
    if_req = 1; dm_req = 1;
    step();
    chk("t2_dm_first_we", mem_we, 1);
    chk("t2_dm_first_addr", mem_addr, 32'h200);
    chk("t2_dm_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("t2_stall_if", stall_if, 1);
    wait_ack(1, 10, "t2_dm_ack");
    chk("t2_stall_if_at_dm_ack", stall_if, 1);
    step();
    chk("t2_bubble", mem_req, 0);
    chk("t2_stall_if_bubble", stall_if, 1);
    step();
    chk("t2_if_grant", mem_req, 1);
    chk("t2_if_we", mem_we, 0);
    chk("t2_if_addr", mem_addr, 32'h100);
    wait_ack(0, 10, "t2_if_ack");
    chk("t2_stall_if_drop", stall_if, 0);
    step();
    glog.delete();
    lat = 0; dm_we = 1; if_hold = 1; dm_hold = 1; if_req = 1; dm_req = 1;
    ndm = 0; got_if = 0; prev = mem_req;
    for (int c = 0; c < 60 && !got_if; c++) begin
      step();
      if (mem_req && !prev) begin
        if (mem_we) ndm++;
        else got_if = 1;
      end
      prev = mem_req;
    end
    chk("t3_if_granted", got_if, 1);
    chk("t3_dm_grants", ndm, 4);
    got = 0; nxt_we = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (mem_req && !prev) begin
        got = 1;
        nxt_we = mem_we;
      end
      prev = mem_req;
    end
    chk("t3_dm_after_if", nxt_we, 1);
    code = 0;
    for (int i = 0; i < 6; i++) code = code * 10 + (i < glog.size() ? glog[i] : 0);
    chk("t3_model_seq", code, 222212);
    if_hold = 0; dm_hold = 0;
    step(12);
    if_req = 0; dm_req = 0;
    step(2);
    auto_mem = 0; force_ack = 0; dm_we = 0; dm_addr = 32'h300; dm_req = 1;
    step();
    chk("t4_gnt", mem_req, 1);
    chk("t4_addr", mem_addr, 32'h300);
    step();
    n_rst = 0; dm_req = 0;
    step();
    chk("t4_rst_drop", mem_req, 0);
    n_rst = 1;
    step(2);
    force_ack = 1;
    step();
    force_ack = 0;
    chk("t4_no_dm_ack", dm_ack, 0);
    chk("t4_idle", mem_req, 0);
    step();
    chk("t4_no_dm_ack2", dm_ack, 0);
    force_ack = 1;
    step(3);
    chk("t5_if_ack", if_ack, 0);
    chk("t5_dm_ack", dm_ack, 0);
    chk("t5_mem_req", mem_req, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_dm_rdata", dm_rdata, 0);
    force_ack = 0; auto_mem = 1;
    step();
`ifdef MEMARB_TIMEOUT_EN
    lat = 1000; if_addr = 32'h400; if_req = 1; hi = 0;
    for (int c = 0; c < 40 && !if_ack; c++) begin
      step();
      if (mem_req) hi++;
    end
    chk("t6_if_ack", if_ack, 1);
    chk("t6_cycles", hi, 16);
    chk("t6_rdata", if_rdata, 32'hDEADBEEF);
    chk("t6_err", err, 1);
    step(5);
    chk("t6_err_sticky", err, 1);
    n_rst = 0;
    step();
    chk("t6_err_cleared", err, 0);
    n_rst = 1; lat = 0;
`else
    hi = 0;
    chk("t6_err_tied", err, 0);
`endif
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
